// File: rtl/spi_ram_pkg.sv
// Shared constants and state encoding for the SPI RAM responder.
package spi_ram_pkg;

    localparam int unsigned CMD_BITS  = 8;
    localparam int unsigned ADDR_BITS = 16;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned CNT_W     = 5;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_IGNORE  = 3'd5
    } state_t;

endpackage

// File: rtl/spi_ram_responder_if.sv
// SPI pins plus local host port of the SPI RAM responder.
interface spi_ram_responder_if #(
    parameter int unsigned ADDR_W = 4
);
    import spi_ram_pkg::*;

    logic                 spi_cs_n;
    logic                 spi_sck;
    logic                 spi_mosi;
    logic                 spi_miso;
    logic                 host_we;
    logic [ADDR_W-1:0]    host_addr;
    logic [DATA_BITS-1:0] host_wdata;
    logic [DATA_BITS-1:0] host_rdata;
    logic                 busy;
    logic                 cmd_err;

    modport slave (
        input  spi_cs_n, spi_sck, spi_mosi, host_we, host_addr, host_wdata,
        output spi_miso, host_rdata, busy, cmd_err
    );

    modport master (
        output spi_cs_n, spi_sck, spi_mosi, host_we, host_addr, host_wdata,
        input  spi_miso, host_rdata, busy, cmd_err
    );

endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for cs_n/sck/mosi plus sck edge strobes.
module spi_pin_sync (
    input  logic clk,
    input  logic i_cs_n,
    input  logic i_sck,
    input  logic i_mosi,
    output logic o_cs_n,
    output logic o_mosi,
    output logic o_sck_rise_c,
    output logic o_sck_fall_c
);

    logic [1:0] r_cs_n;
    logic [1:0] r_mosi;
    logic [2:0] r_sck;

    // Pads are free-running asynchronous inputs; flops just track them.
    always_ff @(posedge clk) begin
        r_cs_n <= {r_cs_n[0], i_cs_n};
        r_mosi <= {r_mosi[0], i_mosi};
        r_sck  <= {r_sck[1:0], i_sck};
    end

    assign o_cs_n       = r_cs_n[1];
    assign o_mosi       = r_mosi[1];
    assign o_sck_rise_c =  r_sck[1] & ~r_sck[2];
    assign o_sck_fall_c = ~r_sck[1] &  r_sck[2];

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 RAM target (READ/WRITE, 16-bit address, bursts) with host port.
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    spi_ram_responder_if.slave  bus
);

    logic                 w_cs_n;
    logic                 w_mosi;
    logic                 w_rise;
    logic                 w_fall;
    logic [7:0]           w_byte;
    logic [ADDR_W-1:0]    w_idx;
    logic [ADDR_W-1:0]    w_ptr_next;

    state_t               r_state;
    logic [6:0]           r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_is_read;
    logic                 r_armed;
    logic [ADDR_W-1:0]    r_ptr;
    logic [DATA_BITS-1:0] r_tx;
    logic                 r_miso;
    logic                 r_cmd_err;
    logic                 r_wr_pend;
    logic [ADDR_W-1:0]    r_wr_idx;
    logic [DATA_BITS-1:0] r_wr_data;
    logic [DATA_BITS-1:0] r_host_rdata;
    logic [DATA_BITS-1:0] r_mem [DEPTH];

    spi_pin_sync u_sync (
        .clk          (clk),
        .i_cs_n       (bus.spi_cs_n),
        .i_sck        (bus.spi_sck),
        .i_mosi       (bus.spi_mosi),
        .o_cs_n       (w_cs_n),
        .o_mosi       (w_mosi),
        .o_sck_rise_c (w_rise),
        .o_sck_fall_c (w_fall)
    );

    // Byte formed by the current shift contents plus the bit being sampled.
    assign w_byte     = {r_shift, w_mosi};
    assign w_idx      = w_byte[ADDR_W-1:0];
    assign w_ptr_next = r_ptr + ADDR_W'(1);

    // Protocol FSM with its datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_is_read <= 1'b0;
            r_armed   <= 1'b0;
            r_ptr     <= '0;
            r_tx      <= '0;
            r_miso    <= 1'b0;
            r_cmd_err <= 1'b0;
            r_wr_pend <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
        end else begin
            r_cmd_err <= 1'b0;
            r_wr_pend <= 1'b0;
            // A transaction may only start after cs_n has been seen high.
            if (w_cs_n) begin
                r_armed <= 1'b1;
            end
            if (w_cs_n && (r_state != ST_IDLE)) begin
                r_state   <= ST_IDLE;
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_tx      <= '0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_cs_n) begin
                            r_state <= r_armed ? ST_CMD : ST_IGNORE;
                        end
                    end
                    ST_CMD: begin
                        if (w_rise) begin
                            r_shift <= w_byte[6:0];
                            if (r_bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                                r_bit_cnt <= '0;
                                case (w_byte)
                                    CMD_READ: begin
                                        r_is_read <= 1'b1;
                                        r_state   <= ST_ADDR;
                                    end
                                    CMD_WRITE: begin
                                        r_is_read <= 1'b0;
                                        r_state   <= ST_ADDR;
                                    end
                                    default: begin
                                        r_cmd_err <= 1'b1;
                                        r_state   <= ST_IGNORE;
                                    end
                                endcase
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_rise) begin
                            r_shift <= w_byte[6:0];
                            if (r_bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                                r_bit_cnt <= '0;
                                r_ptr     <= w_idx;
                                if (r_is_read) begin
                                    r_tx    <= r_mem[w_idx];
                                    r_state <= ST_RD_DATA;
                                end else begin
                                    r_state <= ST_WR_DATA;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_fall) begin
                            r_miso <= r_tx[DATA_BITS-1];
                            if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                                r_bit_cnt <= '0;
                                r_ptr     <= w_ptr_next;
                                r_tx      <= r_mem[w_ptr_next];
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                                r_tx      <= {r_tx[DATA_BITS-2:0], 1'b0};
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_rise) begin
                            r_shift <= w_byte[6:0];
                            if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                                r_bit_cnt <= '0;
                                r_wr_pend <= 1'b1;
                                r_wr_idx  <= r_ptr;
                                r_wr_data <= w_byte;
                                r_ptr     <= w_ptr_next;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_IGNORE: begin
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Memory array: SPI commit has priority over a host write to the same index.
    always_ff @(posedge clk) begin
        if (r_wr_pend) begin
            r_mem[r_wr_idx] <= r_wr_data;
        end
        if (bus.host_we && !(r_wr_pend && (r_wr_idx == bus.host_addr))) begin
            r_mem[bus.host_addr] <= bus.host_wdata;
        end
    end

    // Registered host read port (old data on read-during-write).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_rdata <= '0;
        end else begin
            r_host_rdata <= r_mem[bus.host_addr];
        end
    end

    assign bus.spi_miso   = r_miso;
    assign bus.host_rdata = r_host_rdata;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.cmd_err    = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Self-checking bench: SPI controller model driving the responder against a byte-array reference.
module tb_spi_ram_responder;
    import spi_ram_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned HALF   = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   err_hi   = 0;
    logic [7:0] model [DEPTH];

    always #5 clk = ~clk;

    spi_ram_responder_if #(.ADDR_W(ADDR_W)) bus ();

    spi_ram_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Count clock cycles during which cmd_err is high.
    always @(posedge clk) begin
        if (bus.cmd_err === 1'b1) err_hi++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        bus.spi_mosi = b;
        wait_clk(HALF);
        bus.spi_sck = 1'b1;
        r = bus.spi_miso;
        wait_clk(HALF);
        bus.spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        bus.spi_cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic spi_start(input logic [7:0] cmd, input logic [15:0] addr);
        logic [7:0] r;
        cs_low();
        spi_byte(cmd, r);
        spi_byte(addr[15:8], r);
        spi_byte(addr[7:0], r);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_we    = 1'b1;
        wait_clk(1);
        bus.host_we    = 1'b0;
        model[a] = d;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] d);
        bus.host_addr = a;
        wait_clk(1);
        d = bus.host_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clk(4);
        checks++; if (bus.spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b expected 0", bus.spi_miso); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.cmd_err !== 1'b0) begin failures++; $display("FAIL reset_cmd_err: got %b expected 0", bus.cmd_err); end
        checks++; if (bus.host_rdata !== 8'h00) begin failures++; $display("FAIL reset_host_rdata: got %h expected 00", bus.host_rdata); end
        reset = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_host_port();
        logic [7:0] d;
        logic [7:0] old;
        for (int i = 0; i < int'(DEPTH); i++) host_write(4'(i), 8'($urandom));
        for (int i = 0; i < int'(DEPTH); i++) begin
            host_read(4'(i), d);
            checks++; if (d !== model[i]) begin failures++; $display("FAIL host_readback[%0d]: got %h expected %h", i, d, model[i]); end
        end
        old = model[9];
        bus.host_addr  = 4'd9;
        bus.host_wdata = ~old;
        bus.host_we    = 1'b1;
        wait_clk(1);
        bus.host_we    = 1'b0;
        model[9] = ~old;
        checks++; if (bus.host_rdata !== old) begin failures++; $display("FAIL host_rdw: got %h expected %h", bus.host_rdata, old); end
        host_read(4'd9, d);
        checks++; if (d !== model[9]) begin failures++; $display("FAIL host_after_write: got %h expected %h", d, model[9]); end
    endtask

    task automatic test_read_basic();
        logic [7:0] rx;
        int e0;
        host_write(4'd5, 8'hA7);
        e0 = err_hi;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_before: got %b expected 0", bus.busy); end
        spi_start(CMD_READ, 16'h0005);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_during: got %b expected 1", bus.busy); end
        spi_byte(8'h00, rx);
        checks++; if (rx !== 8'hA7) begin failures++; $display("FAIL read_basic: got %h expected a7", rx); end
        cs_high();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_after: got %b expected 0", bus.busy); end
        checks++; if (bus.spi_miso !== 1'b0) begin failures++; $display("FAIL miso_idle: got %b expected 0", bus.spi_miso); end
        checks++; if (err_hi != e0) begin failures++; $display("FAIL no_cmd_err: got %0d expected 0 cycles", err_hi - e0); end
    endtask

    task automatic test_read_burst();
        logic [7:0]  rx;
        logic [15:0] a;
        int          n;
        spi_start(CMD_READ, 16'h000F);
        spi_byte(8'h00, rx);
        checks++; if (rx !== model[15]) begin failures++; $display("FAIL burst_f: got %h expected %h", rx, model[15]); end
        spi_byte(8'h00, rx);
        checks++; if (rx !== model[0]) begin failures++; $display("FAIL burst_wrap: got %h expected %h", rx, model[0]); end
        cs_high();
        spi_start(CMD_READ, 16'h1235);
        spi_byte(8'h00, rx);
        checks++; if (rx !== model[5]) begin failures++; $display("FAIL read_hi_addr: got %h expected %h", rx, model[5]); end
        cs_high();
        for (int t = 0; t < 5; t++) begin
            a = 16'($urandom);
            n = int'($urandom_range(1, 20));
            spi_start(CMD_READ, a);
            for (int i = 0; i < n; i++) begin
                spi_byte(8'($urandom), rx);
                checks++;
                if (rx !== model[(int'(a[3:0]) + i) % DEPTH]) begin
                    failures++;
                    $display("FAIL rand_read a=%h i=%0d: got %h expected %h", a, i, rx, model[(int'(a[3:0]) + i) % DEPTH]);
                end
            end
            cs_high();
        end
    endtask

    task automatic test_write();
        logic [7:0]  r;
        logic [7:0]  d;
        logic        b;
        logic [15:0] a;
        int          n;
        spi_start(CMD_WRITE, 16'h0003);
        spi_byte(8'h5C, r);
        spi_byte(8'h3E, r);
        for (int i = 0; i < 4; i++) spi_bit(1'($urandom), b);
        cs_high();
        model[3] = 8'h5C;
        model[4] = 8'h3E;
        for (int i = 3; i <= 5; i++) begin
            host_read(4'(i), d);
            checks++; if (d !== model[i]) begin failures++; $display("FAIL write_basic[%0d]: got %h expected %h", i, d, model[i]); end
        end
        for (int t = 0; t < 4; t++) begin
            a = 16'($urandom);
            n = int'($urandom_range(1, 20));
            spi_start(CMD_WRITE, a);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                spi_byte(d, r);
                model[(int'(a[3:0]) + i) % DEPTH] = d;
            end
            cs_high();
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            host_read(4'(i), d);
            checks++; if (d !== model[i]) begin failures++; $display("FAIL write_burst[%0d]: got %h expected %h", i, d, model[i]); end
        end
    endtask

    task automatic spi_write_collide(input logic [3:0] k, input logic [7:0] sd,
                                     input logic [3:0] ha, input logic [7:0] hd);
        logic b;
        spi_start(CMD_WRITE, {12'h000, k});
        for (int i = 7; i >= 1; i--) spi_bit(sd[i], b);
        bus.spi_mosi = sd[0];
        wait_clk(HALF);
        bus.spi_sck = 1'b1;
        // SPI commit lands on the 4th clk after the 8th rise.
        wait_clk(3);
        bus.host_addr  = ha;
        bus.host_wdata = hd;
        bus.host_we    = 1'b1;
        wait_clk(1);
        bus.host_we    = 1'b0;
        wait_clk(HALF - 4);
        bus.spi_sck = 1'b0;
        cs_high();
        if (ha != k) model[ha] = hd;
        model[k] = sd;
    endtask

    task automatic test_collision();
        logic [7:0] d;
        spi_write_collide(4'd7, 8'hC3, 4'd7, 8'h18);
        host_read(4'd7, d);
        checks++; if (d !== model[7]) begin failures++; $display("FAIL collide_same: got %h expected %h", d, model[7]); end
        spi_write_collide(4'd2, 8'h6B, 4'd11, 8'hD4);
        host_read(4'd2, d);
        checks++; if (d !== model[2]) begin failures++; $display("FAIL collide_spi: got %h expected %h", d, model[2]); end
        host_read(4'd11, d);
        checks++; if (d !== model[11]) begin failures++; $display("FAIL collide_host: got %h expected %h", d, model[11]); end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] rx1;
        logic [7:0] rx2;
        logic [7:0] r;
        int e0;
        e0 = err_hi;
        cs_low();
        spi_byte(8'h9F, r);
        spi_byte(8'($urandom), rx1);
        spi_byte(8'($urandom), rx2);
        cs_high();
        checks++; if (err_hi - e0 != 1) begin failures++; $display("FAIL cmd_err_pulse: got %0d cycles expected 1", err_hi - e0); end
        checks++; if ({rx1, rx2} !== 16'h0000) begin failures++; $display("FAIL ignore_miso: got %h expected 0000", {rx1, rx2}); end
        spi_start(CMD_READ, 16'h000A);
        spi_byte(8'h00, r);
        checks++; if (r !== model[10]) begin failures++; $display("FAIL read_after_bad: got %h expected %h", r, model[10]); end
        cs_high();
    endtask

    task automatic test_abort_addr();
        logic [7:0] r;
        logic       b;
        cs_low();
        spi_byte(CMD_WRITE, r);
        spi_byte(8'h00, r);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
        cs_high();
        spi_start(CMD_READ, 16'h0002);
        spi_byte(8'h00, r);
        checks++; if (r !== model[2]) begin failures++; $display("FAIL abort_read: got %h expected %h", r, model[2]); end
        cs_high();
        for (int i = 0; i < int'(DEPTH); i++) begin
            host_read(4'(i), r);
            checks++; if (r !== model[i]) begin failures++; $display("FAIL abort_mem[%0d]: got %h expected %h", i, r, model[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        logic       b;
        host_write(4'd12, 8'hFF);
        host_write(4'd13, 8'hFF);
        spi_start(CMD_READ, 16'h000C);
        spi_byte(8'h00, r);
        checks++; if (r !== model[12]) begin failures++; $display("FAIL pre_reset_read: got %h expected %h", r, model[12]); end
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        checks++; if (bus.spi_miso !== 1'b0) begin failures++; $display("FAIL midreset_miso: got %b expected 0", bus.spi_miso); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        wait_clk(4);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midreset_ignore_busy: got %b expected 1", bus.busy); end
        spi_byte(CMD_READ, r);
        checks++; if (r !== 8'h00) begin failures++; $display("FAIL midreset_ignore_miso: got %h expected 00", r); end
        cs_high();
        spi_start(CMD_READ, 16'h000C);
        spi_byte(8'h00, r);
        checks++; if (r !== model[12]) begin failures++; $display("FAIL post_reset_read: got %h expected %h", r, model[12]); end
        cs_high();
        for (int i = 0; i < int'(DEPTH); i++) begin
            host_read(4'(i), r);
            checks++; if (r !== model[i]) begin failures++; $display("FAIL reset_mem[%0d]: got %h expected %h", i, r, model[i]); end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.spi_cs_n   = 1'b1;
        bus.spi_sck    = 1'b0;
        bus.spi_mosi   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        test_reset();
        test_host_port();
        test_read_basic();
        test_read_burst();
        test_write();
        test_collision();
        test_bad_cmd();
        test_abort_addr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
